uart_rx: RTL and testbench

- 16x-oversampled UART receiver; the direct consumer of the baud generator's tick_16x strobe.
- Synchronises the asynchronous rx line, detects and validates the start bit, samples data LSB-first at bit centres and checks the stop bit.
- Presents each byte on a one-entry valid/ready holding register to the downstream FIFO or core.

---
 rtl/uart_pkg.sv | 16 +
 rtl/bit_sync.sv | 29 ++
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  // PARITY is only reachable when the receiver is built with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVS_FACTOR_DEF = 16;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input; the reset value should
// match the line's idle level so reset never fabricates an edge.
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "bit_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with a one-entry valid/ready holding register.
// Optional parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVS_FACTOR  = OVS_FACTOR_DEF,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  if (OVS_FACTOR < 4 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "uart_rx: OVS_FACTOR must be a power of 2 and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "uart_rx: DATA_BITS must be in 5..9");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "uart_rx: SYNC_STAGES must be at least 2");
  end

  localparam int CW = $clog2(OVS_FACTOR);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] TICK_HALF = CW'(OVS_FACTOR / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_s_d_q;

  rx_state_t state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 par_ok;

  assign par_ok = ((^shift_q) ^ par_q) == PARITY_ODD;
`endif

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s_d_q <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      rx_s_d_q <= rx_s;
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  // Holding register handshake: a word transfers on any clk edge where
  // rx_valid && rx_ready; rx_data is frozen while rx_valid is high, and a
  // completing frame may reload it in the same cycle the old word transfers.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Edge detect runs every clk so a low-held line cannot retrigger.
        if (rx_s_d_q && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (tick_16x) begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick_16x) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_16x) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (tick_16x) begin
          tick_d = tick_q + 1'b1;
          // Finishing at mid-stop leaves half a bit to catch the next start edge.
          if (tick_q == TICK_LAST) begin
            state_d = IDLE;
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_ok) begin
              perr_d = 1'b1;
`endif
            end else if (valid_q && !rx_ready) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a frame-level outcome model and an expected-word queue.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DB  = 8;
  localparam int OVS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif
  // Ticks counted from the tick that drives the start bit low.
  localparam int STOP_TICK = OVS / 2 + OVS * (NB - 1);

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          tick_16x = 1'b0;
  logic          rx       = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [2:0]    dbg_state;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int   tick_div = 54;
  event tick_ev;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0, fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, valid_cyc = 0;
  int exp_xfer = 0, exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [DB-1:0] exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .tick_16x  (tick_16x),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and oversample strobe
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (tick_div - 1) @(posedge clk);
      #1 tick_16x = 1'b1;
      -> tick_ev;
      @(posedge clk);
      #1 tick_16x = 1'b0;
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: run exceeded 150000 cycles, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cyc++;
      if (rx_valid && rx_ready) begin
        xfer_cnt++;
        check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("xfer_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_err) fe_cyc++;
      if (overrun) ov_cyc++;
      if (frame_err || overrun) check("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cyc++;
      if (parity_err) check("pe_alone", 32'(frame_err | overrun | rx_valid & !rx_ready), 32'd0);
`endif
    end
  end

  // Reference model: the outcome of a frame follows from its wire bits and
  // whether the holding register is occupied when the frame ends.
  function automatic logic [15:0] build_bits(input logic [DB-1:0] d, input logic stop_b,
                                             input logic bad_par);
    logic [15:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[DB:1] = d;
`ifdef UART_RX_PARITY_EN
    b[DB+1] = (^d) ^ bad_par;
    b[DB+2] = stop_b;
`else
    b[DB+1] = stop_b;
`endif
    return b;
  endfunction

  task automatic predict(input logic [DB-1:0] d, input logic stop_b, input logic bad_par,
                         input logic ready_at_stop);
    if (!stop_b) exp_fe++;
    else if (bad_par) exp_pe++;
    else if (exp_q.size() > 0 && !ready_at_stop) exp_ov++;
    else begin
      exp_q.push_back(d);
      exp_xfer++;
    end
  endtask

  // Driver tasks
  task automatic idle_ticks(input int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic bad_par,
                            input int ready_tick, input bit chk_busy);
    logic [15:0] bits;
    bits = build_bits(d, stop_b, bad_par);
    predict(d, stop_b, bad_par, rx_ready || (ready_tick == STOP_TICK));
    @(tick_ev);
    rx = bits[0];
    for (int t = 1; t <= NB * OVS; t++) begin
      @(tick_ev);
      if (t % OVS == 0 && t < NB * OVS) rx = bits[4'(t / OVS)];
      if (t == ready_tick) begin
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
      if (chk_busy && t == STOP_TICK) begin
        @(negedge clk);
        check("busy_before_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("valid_latency", 32'(rx_valid), 32'd1);
        check("data_at_valid", 32'(rx_data), 32'(d));
      end
    end
  endtask

  task automatic send_glitch(input int n);
    @(tick_ev);
    rx = 1'b0;
    repeat (n) @(tick_ev);
    rx = 1'b1;
    repeat (OVS) @(tick_ev);
  endtask

  task automatic reset_mid_frame();
    logic [15:0] bits;
    bits = build_bits(8'hFF, 1'b1, 1'b0);
    @(tick_ev);
    rx = 1'b0;
    for (int t = 1; t <= 5 * OVS + 4; t++) begin
      @(tick_ev);
      if (t % OVS == 0) rx = bits[4'(t / OVS)];
    end
    check("mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_data", 32'(rx_data), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ferr", 32'(frame_err), 32'd0);
    check("rst_mid_ovr", 32'(overrun), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rx = 1'b1;
    idle_ticks(NB * OVS);
  endtask

  // Main sequence
  initial begin
    int kind;
    logic [DB-1:0] d;
    logic bad;

    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    rx_ready = 1'b1;
    idle_ticks(2);

    // Clean frame at 54 clks per tick
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b1);
    idle_ticks(4);
    check("clean_xfer", 32'(xfer_cnt), 32'd1);
    check("clean_valid_cycles", 32'(valid_cyc), 32'd1);
    check("clean_ferr", 32'(fe_cyc), 32'd0);

    tick_div = 8;
    idle_ticks(2);

    // Start glitch then a good frame
    send_glitch(3);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_xfer", 32'(xfer_cnt), 32'd1);
    check("glitch_ferr", 32'(fe_cyc), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    idle_ticks(4);
    check("after_glitch_xfer", 32'(xfer_cnt), 32'd2);

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0, 1'b0, 0, 1'b0);
    idle_ticks(20 * OVS);
    check("break_busy", 32'(busy), 32'd0);
    check("break_ferr", 32'(fe_cyc), 32'd1);
    check("break_xfer", 32'(xfer_cnt), 32'd2);
    rx = 1'b1;
    idle_ticks(OVS);
    send_frame(8'h12, 1'b1, 1'b0, 0, 1'b0);
    idle_ticks(4);
    check("after_break_xfer", 32'(xfer_cnt), 32'd3);
    check("after_break_ferr", 32'(fe_cyc), 32'd1);

    // Backpressure and overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
    idle_ticks(4);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_hold_data", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ov_cyc), 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    idle_ticks(2);
    check("ovr_drain_xfer", 32'(xfer_cnt), 32'd4);
    check("ovr_drain_valid", 32'(rx_valid), 32'd0);

    // Simultaneous accept and load
    send_frame(8'h33, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, STOP_TICK, 1'b0);
    idle_ticks(4);
    check("sim_valid", 32'(rx_valid), 32'd1);
    check("sim_data", 32'(rx_data), 32'h44);
    check("sim_no_ovr", 32'(ov_cyc), 32'd1);
    check("sim_xfer", 32'(xfer_cnt), 32'd5);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    idle_ticks(2);
    check("sim_drain_xfer", 32'(xfer_cnt), 32'd6);

    // Reset during data bit 4
    reset_mid_frame();
    check("rst_frame_xfer", 32'(xfer_cnt), 32'd6);
    check("rst_frame_busy", 32'(busy), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
    idle_ticks(4);
    check("parity_err_pulse", 32'(pe_cyc), 32'd1);
    check("parity_no_xfer", 32'(xfer_cnt), 32'd6);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
    rx = 1'b1;
    idle_ticks(4);
    check("parity_vs_ferr", 32'(pe_cyc), 32'd1);
`endif

    // Randomized frames
    for (int i = 0; i < 16; i++) begin
      kind = int'($urandom_range(0, 9));
      d    = DB'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
      bad = (kind == 2) || (kind == 1 && d[0]);
`else
      bad = 1'b0;
`endif
      if (kind == 0) send_glitch(int'($urandom_range(1, 6)));
      else send_frame(d, kind != 1, bad, 0, 1'b0);
      rx = 1'b1;
      idle_ticks(int'($urandom_range(1, 12)));
    end
    idle_ticks(4);

    check("final_xfer", 32'(xfer_cnt), 32'(exp_xfer));
    check("final_ferr", 32'(fe_cyc), 32'(exp_fe));
    check("final_ovr", 32'(ov_cyc), 32'(exp_ov));
    check("final_perr", 32'(pe_cyc), 32'(exp_pe));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
